// File: rtl/booth_mul_sequencer.sv
// ---------------------------------------------------------------------------
// booth_mul_sequencer
//
// Upstream controller and result stage for an 8x8 sequential Booth
// multiplier. Operand pairs arrive over a valid/ready handshake. They are
// registered and held on the multiplier inputs, and a one-cycle start pulse
// is issued. The product is captured on the first cycle the multiplier
// drops busy, and is then offered downstream over valid/ready. A watchdog
// raises a sticky error if busy never falls.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge
// where valid and ready are both 1. The producer holds valid and data
// stable until that edge. The consumer may drive ready freely.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   operand pair present
//   in_ready   out  1   block can accept operands
//   in_mc      in   8   multiplicand (signed)
//   in_mp      in   8   multiplier (signed)
//   mul_start  out  1   start pulse to multiplier
//   mul_mc     out  8   registered multiplicand to multiplier
//   mul_mp     out  8   registered multiplier to multiplier
//   mul_prod   in  16   multiplier product {A,Q}
//   mul_busy   in   1   multiplier busy
//   out_valid  out  1   result held
//   out_ready  in   1   consumer takes result
//   out_prod   out 16   signed product
//   err        out  1   sticky watchdog error
//   dbg_state  out  2   current FSM state (0=IDLE, 1=START, 2=WAIT)
// ---------------------------------------------------------------------------
module booth_mul_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_mc,
    input  logic [7:0]  in_mp,
    output logic        mul_start,
    output logic [7:0]  mul_mc,
    output logic [7:0]  mul_mp,
    input  logic [15:0] mul_prod,
    input  logic        mul_busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_prod,
    output logic        err,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;

    logic accept;
    logic capture;
    logic timeout_hit;
    logic drain;

    // Accept only when fully idle. A pending result or a latched error
    // blocks new work, so a request arriving in the drain cycle is taken
    // one cycle later.
    assign in_ready = !rst && (state == S_IDLE) && !out_valid && !err;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    // The multiplier keeps shifting after it finishes and its count wraps,
    // so the product is only valid on the first busy-low cycle. mul_busy
    // is meaningful only in WAIT.
    assign capture     = (state == S_WAIT) && !mul_busy;
    assign timeout_hit = (state == S_WAIT) && mul_busy &&
                         (wait_cnt == CW'(TIMEOUT - 1));

    assign mul_start = (state == S_START);
    assign dbg_state = state;

    // Next-state logic
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                state_nxt    = S_WAIT;
                wait_cnt_nxt = '0;
            end
            S_WAIT: begin
                if (capture || timeout_hit) begin
                    state_nxt    = S_IDLE;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt    = S_IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Operand, result and error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_mc    <= '0;
            mul_mp    <= '0;
            out_valid <= 1'b0;
            out_prod  <= '0;
            err       <= 1'b0;
        end else begin
            // Operands only change on accept, so they stay stable through
            // START and WAIT.
            if (accept) begin
                mul_mc <= in_mc;
                mul_mp <= in_mp;
            end
            // capture is only reachable with out_valid low, so it never
            // collides with a drain.
            if (capture) begin
                out_prod  <= mul_prod;
                out_valid <= 1'b1;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
            if (timeout_hit) begin
                err <= 1'b1;
            end
        end
    end

endmodule
